// File: rtl/uart_rx_core_if.sv
// Parallel/serial signal bundle between the UART receive core and its line/consumer side.
// The slave modport is the receiver; the master modport is the line driver plus word consumer.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serial_in;
  logic                  parity_en;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  framing_error;
  logic                  busy;

  modport master (
    output serial_in,
    output parity_en,
    input  rx_data,
    input  data_valid,
    input  parity_error,
    input  framing_error,
    input  busy
  );

  modport slave (
    input  serial_in,
    input  parity_en,
    output rx_data,
    output data_valid,
    output parity_error,
    output framing_error,
    output busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/optional even parity/stop recovery,
// delivering each word with a one-cycle valid strobe and sticky error flags.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic           UCLK,
  input  logic           reset,
  uart_rx_core_if.slave  rx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_t                state, state_nxt;
  logic                  rx_p0, rx_p1, rx_p2;
  logic [CNT_W-1:0]      sample_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  data_xor;
  logic                  par_en_q;
  logic                  par_err_q;
  logic                  fall;
  logic                  cnt_clr, start_frame, data_go, shift_en, par_smp, stop_smp;

  // rx_p1 is the synchronised line; rx_p2 is its previous value for edge detection
  assign fall = rx_p2 & ~rx_p1;

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    start_frame = 1'b0;
    data_go     = 1'b0;
    shift_en    = 1'b0;
    par_smp     = 1'b0;
    stop_smp    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) begin
          state_nxt   = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        // Mid-bit recheck rejects short low glitches on an idle line
        if (sample_cnt == MID_CNT) begin
          cnt_clr = 1'b1;
          if (rx_p1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            data_go   = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_cnt == END_CNT) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_cnt == END_CNT) begin
          cnt_clr   = 1'b1;
          par_smp   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample_cnt == END_CNT) begin
          cnt_clr   = 1'b1;
          stop_smp  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Synchroniser, counters and output registers
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      rx_p0               <= 1'b1;
      rx_p1               <= 1'b1;
      rx_p2               <= 1'b1;
      sample_cnt          <= '0;
      bit_cnt             <= '0;
      par_en_q            <= 1'b0;
      rx_if.rx_data       <= '0;
      rx_if.data_valid    <= 1'b0;
      rx_if.parity_error  <= 1'b0;
      rx_if.framing_error <= 1'b0;
    end else begin
      rx_p0            <= rx_if.serial_in;
      rx_p1            <= rx_p0;
      rx_p2            <= rx_p1;
      sample_cnt       <= cnt_clr ? '0 : sample_cnt + 1'b1;
      rx_if.data_valid <= stop_smp;
      if (start_frame) par_en_q <= rx_if.parity_en;
      if (data_go) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      // The word is delivered even when a flag is raised
      if (stop_smp) begin
        rx_if.rx_data       <= shift_reg;
        rx_if.framing_error <= ~rx_p1;
        rx_if.parity_error  <= par_en_q & par_err_q;
      end
    end
  end

  // Data shifter and parity accumulator carry no reset; they are qualified by the FSM
  always_ff @(posedge UCLK) begin
    if (data_go) data_xor <= 1'b0;
    else if (shift_en) data_xor <= data_xor ^ rx_p1;
    if (shift_en) shift_reg <= {rx_p1, shift_reg[DATA_WIDTH-1:1]};
    if (par_smp) par_err_q <= rx_p1 ^ data_xor;
  end

  assign rx_if.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scenario bench for uart_rx_core: drives serial frames and compares each delivered
// word against the frame rules (LSB-first data, even parity, stop level).
module tb_uart_rx_core;

  localparam int OS = 8;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } rec_t;

  logic UCLK = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   errors = 0;
  int   checks = 0;
  rec_t q[$];

  uart_rx_core_if #(.DATA_WIDTH(8)) ifc ();

  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .UCLK  (UCLK),
    .reset (reset),
    .rx_if (ifc)
  );

  always #5 UCLK = ~UCLK;
  always @(posedge UCLK) cyc <= cyc + 1;

  // Every strobe cycle becomes one record, so a stretched strobe shows up as an extra word
  always @(negedge UCLK) begin
    if (ifc.data_valid === 1'b1)
      q.push_back('{d: ifc.rx_data, pe: ifc.parity_error, fe: ifc.framing_error, c: cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    ifc.serial_in = b;
    repeat (OS) @(posedge UCLK);
    #1;
  endtask

  task automatic idle(input int n);
    ifc.serial_in = 1'b1;
    repeat (n) @(posedge UCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stop, input bit flip_pen);
    ifc.parity_en = pen;
    fall_cyc = cyc;
    drive_bit(1'b0);
    if (flip_pen) ifc.parity_en = ~pen;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic get_word(output rec_t r, output bit ok);
    r = '{d: 8'h00, pe: 1'b0, fe: 1'b0, c: 0};
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge UCLK);
    end
  endtask

  task automatic test_reset;
    ifc.serial_in = 1'b1;
    ifc.parity_en = 1'b0;
    repeat (3) @(posedge UCLK);
    #1;
    checks++; if (ifc.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", ifc.rx_data); end
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.data_valid); end
    checks++; if (ifc.parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", ifc.parity_error); end
    checks++; if (ifc.framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ifc.framing_error); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
    reset = 1'b0;
    idle(6);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", ifc.busy); end
  endtask

  task automatic test_basic;
    rec_t r; bit ok; int lat;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    get_word(r, ok);
    lat = r.c - fall_cyc;
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got none exp one word"); end
    checks++; if (r.d !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", r.d); end
    checks++; if (r.pe !== 1'b0 || r.fe !== 1'b0) begin errors++; $display("FAIL basic_flags got pe=%b fe=%b exp 0 0", r.pe, r.fe); end
    checks++; if (lat < 78 || lat > 80) begin errors++; $display("FAIL basic_latency got %0d exp 79+-1", lat); end
    idle(8);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", ifc.busy); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL basic_pulses got %0d extra exp 0", q.size()); end
  endtask

  task automatic test_parity;
    rec_t r; bit ok; int lat;
    for (int k = 0; k < 2; k++) begin
      bit pbit;
      bit exp_pe;
      pbit = (k == 1);
      exp_pe = pbit ^ (^8'h3C);
      // second frame toggles parity_en after start detect; the latched setting must win
      send_frame(8'h3C, 1'b1, pbit, 1'b1, k == 1);
      ifc.parity_en = 1'b1;
      get_word(r, ok);
      lat = r.c - fall_cyc;
      checks++; if (!ok) begin errors++; $display("FAIL parity_timeout[%0d] got none exp one word", k); end
      checks++; if (r.d !== 8'h3C) begin errors++; $display("FAIL parity_data[%0d] got %h exp 3c", k, r.d); end
      checks++; if (r.pe !== exp_pe) begin errors++; $display("FAIL parity_flag[%0d] got %b exp %b", k, r.pe, exp_pe); end
      checks++; if (r.fe !== 1'b0) begin errors++; $display("FAIL parity_ferr[%0d] got %b exp 0", k, r.fe); end
      checks++; if (lat < 86 || lat > 88) begin errors++; $display("FAIL parity_latency[%0d] got %0d exp 87+-1", k, lat); end
      idle(8);
    end
    ifc.parity_en = 1'b0;
  endtask

  task automatic test_framing;
    rec_t r; bit ok;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    get_word(r, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got none exp one word"); end
    checks++; if (r.d !== 8'h81) begin errors++; $display("FAIL frame_data got %h exp 81", r.d); end
    checks++; if (r.fe !== 1'b1) begin errors++; $display("FAIL frame_ferr got %b exp 1", r.fe); end
    ifc.serial_in = 1'b0;
    repeat (120) @(posedge UCLK);
    #1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL break_words got %0d exp 0", q.size()); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", ifc.busy); end
    checks++; if (ifc.framing_error !== 1'b1) begin errors++; $display("FAIL break_ferr_hold got %b exp 1", ifc.framing_error); end
    idle(16);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    get_word(r, ok);
    checks++; if (!ok || r.d !== 8'h42) begin errors++; $display("FAIL after_break_data got %h ok=%b exp 42", r.d, ok); end
    checks++; if (r.fe !== 1'b0) begin errors++; $display("FAIL after_break_ferr got %b exp 0", r.fe); end
    idle(8);
  endtask

  task automatic test_glitch;
    bit saw_busy;
    saw_busy = 1'b0;
    ifc.serial_in = 1'b0;
    repeat (3) @(posedge UCLK);
    #1;
    ifc.serial_in = 1'b1;
    for (int i = 0; i < OS / 2 + 4; i++) begin
      @(posedge UCLK);
      #1;
      if (ifc.busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_seen got busy=0 exp pulse"); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", ifc.busy); end
    idle(24);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL glitch_words got %0d exp 0", q.size()); end
  endtask

  task automatic test_back_to_back;
    rec_t r0, r1; bit ok0, ok1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    get_word(r0, ok0);
    get_word(r1, ok1);
    checks++; if (!ok0 || r0.d !== 8'h55) begin errors++; $display("FAIL b2b_first got %h ok=%b exp 55", r0.d, ok0); end
    checks++; if (!ok1 || r1.d !== 8'hAA) begin errors++; $display("FAIL b2b_second got %h ok=%b exp aa", r1.d, ok1); end
    checks++; if ({r0.pe, r0.fe, r1.pe, r1.fe} !== 4'b0000) begin errors++; $display("FAIL b2b_flags got %b exp 0000", {r0.pe, r0.fe, r1.pe, r1.fe}); end
    idle(16);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d exp 0", q.size()); end
  endtask

  task automatic test_reset_mid;
    rec_t r; bit ok;
    ifc.parity_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", ifc.busy); end
    #3 reset = 1'b1;
    #1;
    checks++; if (ifc.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data got %h exp 00", ifc.rx_data); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ifc.busy); end
    checks++; if ({ifc.data_valid, ifc.parity_error, ifc.framing_error} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {ifc.data_valid, ifc.parity_error, ifc.framing_error}); end
    ifc.serial_in = 1'b1;
    @(posedge UCLK);
    #1;
    reset = 1'b0;
    idle(16);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL midrst_words got %0d exp 0", q.size()); end
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    get_word(r, ok);
    checks++; if (!ok || r.d !== 8'h0F) begin errors++; $display("FAIL postrst_data got %h ok=%b exp 0f", r.d, ok); end
    checks++; if (r.pe !== 1'b0 || r.fe !== 1'b0) begin errors++; $display("FAIL postrst_flags got pe=%b fe=%b exp 0 0", r.pe, r.fe); end
    idle(8);
  endtask

  task automatic test_random;
    rec_t r; bit ok;
    bit prev_stop;
    prev_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit pen, pbit, stop, flip, exp_pe, exp_fe;
      int gap;
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      flip = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      if (!prev_stop && gap == 0) gap = 1;
      if (gap > 0) idle(gap * OS);
      send_frame(d, pen, pbit, stop, flip);
      exp_pe = pen & (pbit ^ (^d));
      exp_fe = ~stop;
      prev_stop = stop;
      get_word(r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout[%0d] got none exp one word", n); end
      checks++; if (r.d !== d) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", n, r.d, d); end
      checks++; if (r.pe !== exp_pe) begin errors++; $display("FAIL rand_perr[%0d] got %b exp %b", n, r.pe, exp_pe); end
      checks++; if (r.fe !== exp_fe) begin errors++; $display("FAIL rand_ferr[%0d] got %b exp %b", n, r.fe, exp_fe); end
    end
    idle(16);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_extra got %0d exp 0", q.size()); end
  endtask

  initial begin
    ifc.serial_in = 1'b1;
    ifc.parity_en = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
